// File: rtl/uart_fram_cmd.sv
// rtl/uart_fram_cmd.sv - UART command front-end issuing single-word FRAM requests
// Parses 'W' addr data / 'R' addr from 8N1 input; replies 'K'/'E'/'?' plus read data.
module uart_fram_cmd #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       req_valid,
  input  logic       req_ready,
  output logic       req_write,
  output logic [7:0] req_addr,
  output logic [7:0] req_wdata,
  input  logic       rsp_valid,
  input  logic       rsp_error,
  input  logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CLKS);
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_Q = 8'h3F;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {
    P_IDLE, P_GET_ADDR, P_GET_DATA, P_ISSUE, P_WAIT_RSP, P_SEND_STATUS, P_SEND_DATA
  } p_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_stb_q, byte_stb_d;
  logic          frame_err_q, frame_err_d;

  logic          tx_q, tx_d;
  logic          tx_active_q, tx_active_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_done, tx_load;
  logic [7:0]    tx_byte;

  p_state_e      p_state_q, p_state_d;
  logic          write_q, write_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    status_q, status_d, rdata_q, rdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_get, timeout;

  // Receiver: start bit re-checked mid-bit so short glitches are rejected.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        byte_stb_d  = rx_sync_q;
        frame_err_d = !rx_sync_q;
        rx_state_d  = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign tx_done = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_LAST);

  // A load on the done cycle starts the next frame with no idle gap.
  always_comb begin
    tx_active_d = tx_active_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_active_q) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = tx_bit_q + 1'b1;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) tx_active_d = 1'b0;
      end
    end
    if (tx_load) begin
      tx_active_d = 1'b1;
      tx_shift_d  = {1'b1, tx_byte, 1'b0};
      tx_bit_d    = '0;
      tx_cnt_d    = '0;
    end
    tx_d = tx_active_d ? tx_shift_d[0] : 1'b1;
  end

  assign in_get  = (p_state_q == P_GET_ADDR) || (p_state_q == P_GET_DATA);
  assign timeout = in_get && (tmo_q == TMO_MAX);

  always_comb begin
    p_state_d = p_state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    tx_load   = 1'b0;
    tx_byte   = status_q;
    tmo_d     = (in_get && !byte_stb_q && !timeout) ? tmo_q + 1'b1 : '0;
    case (p_state_q)
      P_IDLE: if (byte_stb_q) begin
        if (rx_shift_q == CH_W || rx_shift_q == CH_R) begin
          write_d   = (rx_shift_q == CH_W);
          p_state_d = P_GET_ADDR;
        end else begin
          status_d  = CH_Q;
          tx_byte   = CH_Q;
          tx_load   = 1'b1;
          p_state_d = P_SEND_STATUS;
        end
      end
      P_GET_ADDR: begin
        if (byte_stb_q) begin
          addr_d    = rx_shift_q;
          p_state_d = write_q ? P_GET_DATA : P_ISSUE;
        end else if (timeout) begin
          p_state_d = P_IDLE;
        end
      end
      P_GET_DATA: begin
        if (byte_stb_q) begin
          wdata_d   = rx_shift_q;
          p_state_d = P_ISSUE;
        end else if (timeout) begin
          p_state_d = P_IDLE;
        end
      end
      P_ISSUE: if (req_ready) p_state_d = P_WAIT_RSP;
      P_WAIT_RSP: if (rsp_valid) begin
        status_d  = rsp_error ? CH_E : CH_K;
        rdata_d   = rsp_rdata;
        tx_byte   = rsp_error ? CH_E : CH_K;
        tx_load   = 1'b1;
        p_state_d = P_SEND_STATUS;
      end
      P_SEND_STATUS: if (tx_done) begin
        if (status_q == CH_K && !write_q) begin
          tx_byte   = rdata_q;
          tx_load   = 1'b1;
          p_state_d = P_SEND_DATA;
        end else begin
          p_state_d = P_IDLE;
        end
      end
      P_SEND_DATA: if (tx_done) p_state_d = P_IDLE;
      default: p_state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      p_state_q   <= P_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      tmo_q       <= '0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
      tx_q        <= tx_d;
      tx_active_q <= tx_active_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      p_state_q   <= p_state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      tmo_q       <= tmo_d;
    end
  end

  assign tx        = tx_q;
  assign req_valid = (p_state_q == P_ISSUE);
  assign req_write = write_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign busy      = (p_state_q != P_IDLE);
  assign frame_err = frame_err_q;

endmodule

// File: doc/uart_fram_cmd.md
Name: uart_fram_cmd

Overview:
UART command front-end for the FRAM access controller. It deserialises 8N1 bytes from the host and parses binary write/read commands. Each command becomes a single-word request on a valid/ready interface to the I2C FRAM controller, and the outcome is serialised back to the host. The block drives the controller's request inputs and consumes its response.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
TIMEOUT_CLKS, 1000000, idle clk cycles allowed between bytes of one command before it is discarded.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  UART receive line, asynchronous, idle high
tx  out  1  UART transmit line, idle high
req_valid  out  1  FRAM request valid
req_ready  in  1  FRAM controller accepts request
req_write  out  1  1 = write, 0 = read
req_addr  out  8  FRAM word address
req_wdata  out  8  write data
rsp_valid  in  1  one-cycle pulse: request complete
rsp_error  in  1  qualified by rsp_valid: missed ACK / bus failure
rsp_rdata  in  8  qualified by rsp_valid: read data
busy  out  1  high whenever parser state != IDLE
frame_err  out  1  one-cycle pulse on a received byte with bad stop bit

Behaviour:
- Reset: clk and rst are as stated in Ports (rst synchronous, active-high). Reset values: tx=1, req_valid=0, req_write=0, req_addr=0, req_wdata=0, busy=0, frame_err=0; parser IDLE, RX/TX engines idle.
- Reset mid-operation aborts everything. Any partial TX frame is truncated and tx is high from the cycle after rst.
- RX path:
  - rx passes through a 2-FF synchroniser.
  - A falling edge in RX idle starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the frame is a glitch and RX returns to idle.
  - The 8 data bits are sampled LSB first, each CLKS_PER_BIT apart.
  - If the stop bit samples 0: pulse frame_err and discard the byte. Otherwise emit a one-cycle internal byte strobe at the stop-bit sample.
- TX path: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles. The next byte may begin the cycle after the stop bit ends.
- Parser states:
  - IDLE: byte 0x57 'W' -> GET_ADDR with write=1. Byte 0x52 'R' -> GET_ADDR with write=0. Any other byte -> SEND_STATUS with status 0x3F '?'.
  - GET_ADDR: byte -> latch req_addr. If write -> GET_DATA; if read -> ISSUE.
  - GET_DATA: byte -> latch req_wdata -> ISSUE.
  - ISSUE: req_valid=1 with req_write/req_addr/req_wdata held stable. On req_valid & req_ready (same cycle), req_valid drops the next cycle and the parser enters WAIT_RSP.
  - WAIT_RSP: on rsp_valid, status = rsp_error ? 0x45 'E' : 0x4B 'K'; latch rsp_rdata -> SEND_STATUS. No timeout is applied here.
  - SEND_STATUS: transmit the status byte. If status is 'K' and the command was a read -> SEND_DATA; otherwise -> IDLE.
  - SEND_DATA: transmit the latched read byte -> IDLE.
- Inter-byte timeout: a counter clears on every byte strobe and runs only in GET_ADDR/GET_DATA. When it reaches TIMEOUT_CLKS, the parser returns to IDLE with no reply and no request.
- Bytes received in ISSUE, WAIT_RSP, SEND_STATUS or SEND_DATA are dropped (no queuing).
- rsp_valid outside WAIT_RSP is ignored.
- A byte strobe and a timeout in the same cycle: the byte wins and the counter clears.
- A framing-error byte is never passed to the parser and does not reset the timeout.
- busy=1 from the cycle after leaving IDLE until the cycle after the final stop bit completes.

Test Plan:
- CLKS_PER_BIT=16; host sends 0x57,0x04,0xA5; controller asserts req_ready 3 cycles after req_valid, then rsp_valid, rsp_error=0 -> exactly one request (write=1, addr=0x04, wdata=0xA5) and tx frame 0x4B.
- Host sends 0x52,0x04; rsp_valid with rsp_rdata=0x3C, rsp_error=0 -> req write=0 addr=0x04; tx frames 0x4B then 0x3C back-to-back.
- Read with rsp_error=1 -> tx sends only 0x45; busy falls after its stop bit.
- Host sends 0x00 -> tx 0x3F; no req_valid. A byte with stop bit 0 -> frame_err pulse, no tx, parser stays IDLE.
- TIMEOUT_CLKS=200; send 0x57,0x10, then silence for 300 cycles, then 0x52,0x10 -> no write request; a read request for addr 0x10 is issued.
- Assert rst while req_valid=1, then release; host sends 0x52,0x01 -> req_valid=0 and tx=1 the cycle after rst; afterwards a clean read request for addr 0x01 is issued.
